ascon_permutation_iter: RTL and testbench

- Iterative ASCON permutation core. Wraps one combinational round (constant addition, S-box substitution, linear diffusion) around a 320-bit state register.
- Runs either p12 (12 rounds) or p6 (6 rounds), one round per clock.
- Directly consumes the diffusion layer output: diffusion result feeds back into the state register each cycle.
- Sits between the ASCON mode FSM (init/AD/plaintext/finalisation) and the round datapath.

---
 rtl/ascon_permutation_iter.sv | 147 ++++++++++++++
 tb/tb_ascon_permutation_iter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_iter.sv
// ---------------------------------------------------------------------------
// ascon_permutation_iter
//
// Iterative ASCON permutation core. A single combinational round (constant
// addition, 5-bit S-box substitution, linear diffusion) is wrapped around a
// 320-bit state register and applied once per clock. It runs either p12
// (round indices 0..11) or p6 (round indices 6..11). It sits between the
// ASCON mode FSM and the round datapath.
//
// Ports
//   clock_i   in   1        system clock, rising edge
//   resetb_i  in   1        asynchronous active-low reset
//   start_i   in   1        start request; accepted in IDLE or DONE
//   mode_i    in   1        0 = p12, 1 = p6; sampled with start_i
//   state_i   in   5x64     input state x0..x4 (index 0 = x0); sampled with start_i
//   state_o   out  5x64     state register contents (no bypass)
//   busy_o    out  1        high while rounds are running
//   done_o    out  1        one-cycle pulse once the final round is written
//   round_o   out  4        round index about to be applied (12 once finished)
// ---------------------------------------------------------------------------
module ascon_permutation_iter #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic        clock_i,
  input  logic        resetb_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [63:0] state_i [5],
  output logic [63:0] state_o [5],
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  round_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_t;

  // Both variants end on round index 11; the shorter one simply starts later.
  localparam logic [3:0] FIRST_A    = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] FIRST_B    = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  fsm_t        fsm_q, fsm_d;
  logic [63:0] state_q [5];
  logic [63:0] state_d [5];
  logic [3:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [63:0] c_x [5];  // after constant addition
  logic [63:0] a_x [5];  // S-box input mixing
  logic [63:0] b_x [5];  // after chi-like nonlinear step
  logic [63:0] s_x [5];  // S-box output
  logic [63:0] l_x [5];  // diffusion output, fed back to the register

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Gives F0, E1, D2, ... 4B for r = 0..11.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return 8'hF0 - ({4'd0, r} * 8'h0F);
  endfunction

  // Constant addition touches only the low byte of x2.
  assign c_x[0] = state_q[0];
  assign c_x[1] = state_q[1];
  assign c_x[2] = state_q[2] ^ {56'd0, round_const(round_q)};
  assign c_x[3] = state_q[3];
  assign c_x[4] = state_q[4];

  // Bit-sliced S-box: every bit position is one 5-bit column, x0 as MSB.
  assign a_x[0] = c_x[0] ^ c_x[4];
  assign a_x[1] = c_x[1];
  assign a_x[2] = c_x[2] ^ c_x[1];
  assign a_x[3] = c_x[3];
  assign a_x[4] = c_x[4] ^ c_x[3];

  assign b_x[0] = a_x[0] ^ (~a_x[1] & a_x[2]);
  assign b_x[1] = a_x[1] ^ (~a_x[2] & a_x[3]);
  assign b_x[2] = a_x[2] ^ (~a_x[3] & a_x[4]);
  assign b_x[3] = a_x[3] ^ (~a_x[4] & a_x[0]);
  assign b_x[4] = a_x[4] ^ (~a_x[0] & a_x[1]);

  assign s_x[0] = b_x[0] ^ b_x[4];
  assign s_x[1] = b_x[1] ^ b_x[0];
  assign s_x[2] = ~b_x[2];
  assign s_x[3] = b_x[3] ^ b_x[2];
  assign s_x[4] = b_x[4];

  // Linear diffusion, one rotation pair per word.
  assign l_x[0] = s_x[0] ^ rotr(s_x[0], 19) ^ rotr(s_x[0], 28);
  assign l_x[1] = s_x[1] ^ rotr(s_x[1], 61) ^ rotr(s_x[1], 39);
  assign l_x[2] = s_x[2] ^ rotr(s_x[2],  1) ^ rotr(s_x[2],  6);
  assign l_x[3] = s_x[3] ^ rotr(s_x[3], 10) ^ rotr(s_x[3], 17);
  assign l_x[4] = s_x[4] ^ rotr(s_x[4],  7) ^ rotr(s_x[4], 41);

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    for (int i = 0; i < 5; i++) state_d[i] = state_q[i];

    case (fsm_q)
      ST_RUN: begin
        for (int i = 0; i < 5; i++) state_d[i] = l_x[i];
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) fsm_d = ST_DONE;
      end
      default: begin
        // IDLE and DONE both accept a start, so back-to-back runs lose only
        // the DONE cycle. Without a start, DONE falls back to IDLE and the
        // state and round index are held.
        fsm_d = ST_IDLE;
        if (start_i) begin
          for (int i = 0; i < 5; i++) state_d[i] = state_i[i];
          round_d = mode_i ? FIRST_B : FIRST_A;
          fsm_d   = ST_RUN;
        end
      end
    endcase

    busy_d = (fsm_d == ST_RUN);
    done_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 5; i++) state_q[i] <= 64'd0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 5; i++) state_q[i] <= state_d[i];
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign round_o = round_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// ---------------------------------------------------------------------------
// tb_ascon_permutation_iter
//
// Directed bench for ascon_permutation_iter. A reference model computes each
// run as a precomputed trajectory of states (table S-box, table round
// constants, rotate-by-concatenation diffusion); a compare process checks all
// outputs on every falling clock edge against it. Hand-computed literals pin
// the model itself and a few DUT points.
// ---------------------------------------------------------------------------
module tb_ascon_permutation_iter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [63:0] st_in  [5];
  logic [63:0] st_out [5];
  logic        busy;
  logic        done;
  logic [3:0]  rnd;
  logic [319:0] out_flat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [7:0] RC_TAB [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                         8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam logic [319:0] VEC_P6 = {64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7,
                                     64'h4b81c0cbbdb5fc1a, 64'hb22e133e424f0250,
                                     64'h044d33702433805d};
  localparam logic [319:0] VEC_B  = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                     64'h0000000000000000, 64'hffffffffffffffff,
                                     64'h8000000000000001};
  // One round (index 0) applied to the all-zero state, worked out by hand.
  localparam logic [319:0] R0_LIT = {64'h001E0F00000000F0, 64'h00000001E0000770,
                                     64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0,
                                     64'h0000000000000000};

  ascon_permutation_iter dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start),
    .mode_i   (mode),
    .state_i  (st_in),
    .state_o  (st_out),
    .busy_o   (busy),
    .done_o   (done),
    .round_o  (rnd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign out_flat = {st_out[0], st_out[1], st_out[2], st_out[3], st_out[4]};

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] t;
    t = {v, v} >> n;
    return t[63:0];
  endfunction

  function automatic logic [319:0] m_pcon(input logic [319:0] s, input int r);
    logic [319:0] o;
    o = s;
    o[135:128] = o[135:128] ^ RC_TAB[r];
    return o;
  endfunction

  function automatic logic [319:0] m_sbox(input logic [319:0] s);
    logic [319:0] o;
    logic [4:0]   col;
    logic [4:0]   v;
    o = '0;
    for (int c = 0; c < 64; c++) begin
      for (int i = 0; i < 5; i++) col[4-i] = s[64*(4-i) + c];
      v = SBOX[col];
      for (int i = 0; i < 5; i++) o[64*(4-i) + c] = v[4-i];
    end
    return o;
  endfunction

  function automatic logic [319:0] m_diff(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    return {x0 ^ ror(x0, 19) ^ ror(x0, 28),
            x1 ^ ror(x1, 61) ^ ror(x1, 39),
            x2 ^ ror(x2,  1) ^ ror(x2,  6),
            x3 ^ ror(x3, 10) ^ ror(x3, 17),
            x4 ^ ror(x4,  7) ^ ror(x4, 41)};
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    return m_diff(m_sbox(m_pcon(s, r)));
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int first);
    logic [319:0] o;
    o = s;
    for (int r = first; r < 12; r++) o = m_round(o, r);
    return o;
  endfunction

  // Run tracker: k = edges since the accepted start; k == n_run is the DONE cycle.
  logic [319:0] traj [13];
  logic [319:0] hold_st  = '0;
  logic [3:0]   hold_rnd = 4'd0;
  bit           active   = 1'b0;
  int           k        = 0;
  int           n_run    = 0;
  int           r0       = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   = 1'b0;
      hold_st  = '0;
      hold_rnd = 4'd0;
    end else if (start && (!active || k >= n_run)) begin
      n_run   = mode ? 6 : 12;
      r0      = 12 - n_run;
      traj[0] = {st_in[0], st_in[1], st_in[2], st_in[3], st_in[4]};
      for (int j = 1; j <= n_run; j++) traj[j] = m_round(traj[j-1], r0 + j - 1);
      k      = 0;
      active = 1'b1;
    end else if (active) begin
      k++;
      if (k > n_run) begin
        active   = 1'b0;
        hold_st  = traj[n_run];
        hold_rnd = 4'd12;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [319:0] e_st;
    logic [3:0]   e_rnd;
    logic         e_busy;
    logic         e_done;
    if (!active) begin
      e_st = hold_st;  e_rnd = hold_rnd;     e_busy = 1'b0; e_done = 1'b0;
    end else if (k < n_run) begin
      e_st = traj[k];  e_rnd = 4'(r0 + k);   e_busy = 1'b1; e_done = 1'b0;
    end else begin
      e_st = traj[n_run]; e_rnd = 4'd12;     e_busy = 1'b0; e_done = 1'b1;
    end
    chk("cyc_state_o", out_flat, e_st);
    chk_int("cyc_round_o", int'(rnd), int'(e_rnd));
    chk_int("cyc_busy_o", int'(busy), int'(e_busy));
    chk_int("cyc_done_o", int'(done), int'(e_done));
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [319:0] s);
    for (int i = 0; i < 5; i++) st_in[i] = s[64*(4-i) +: 64];
  endtask

  // Called #1 after a rising edge; returns #1 after the start edge.
  task automatic do_start(input logic m, input logic [319:0] s, output int s_edge);
    mode  = m;
    set_in(s);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    s_edge = cyc;
  endtask

  task automatic wait_done(output int e);
    e = -1;
    repeat (40) begin
      if (e < 0) begin
        @(posedge clk); #1;
        if (done) e = cyc;
      end
    end
    if (e < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout actual=no_done required=done_o within 40 cycles");
    end
  endtask

  task automatic wait_round(input logic [3:0] target);
    int n = 0;
    while (rnd != target && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk_int("wait_round", int'(rnd), int'(target));
  endtask

  logic [319:0] gold_z12, gold_v6, gold_b6;
  int s_edge, e_edge, d1, d2;

  initial begin
    set_in('0);

    // Model pins against hand-computed values.
    chk("pin_sbox_zero", m_sbox(m_pcon('0, 0)),
        {64'hF0, 64'hF0, 64'hFFFFFFFFFFFFFF0F, 64'hF0, 64'h0});
    chk("pin_sbox_col10", m_sbox({64'h1, 256'd0}),
        {64'h1, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0});
    chk("pin_pcon_r6", m_pcon('0, 6), {64'h0, 64'h0, 64'h96, 64'h0, 64'h0});
    chk("pin_round_zero", m_round('0, 0), R0_LIT);

    gold_z12 = m_perm('0, 0);
    gold_v6  = m_perm(VEC_P6, 6);
    gold_b6  = m_perm(VEC_B, 6);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_o", out_flat, '0);
    chk_int("reset_round_o", int'(rnd), 0);
    chk_int("reset_busy_o", int'(busy), 0);
    chk_int("reset_done_o", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a p12 run aborts immediately.
    do_start(1'b0, VEC_P6, s_edge);
    wait_round(4'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state_o", out_flat, '0);
    chk_int("abort_round_o", int'(rnd), 0);
    chk_int("abort_busy_o", int'(busy), 0);
    chk_int("abort_done_o", int'(done), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // p12 on the all-zero state.
    do_start(1'b0, '0, s_edge);
    chk_int("p12_first_round", int'(rnd), 0);
    @(posedge clk); #1;
    chk("p12_after_round0", out_flat, R0_LIT);
    wait_done(e_edge);
    chk_int("p12_latency", e_edge - s_edge, 12);
    chk("p12_result", out_flat, gold_z12);
    @(posedge clk); #1;

    // Start pulse with a different state during RUN is ignored.
    do_start(1'b0, '0, s_edge);
    wait_round(4'd3);
    set_in(VEC_P6);
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e_edge);
    chk_int("ignored_start_latency", e_edge - s_edge, 12);
    chk("ignored_start_result", out_flat, gold_z12);
    @(posedge clk); #1;

    // p6 on the reference vector.
    do_start(1'b1, VEC_P6, s_edge);
    chk_int("p6_first_round", int'(rnd), 6);
    wait_done(e_edge);
    chk_int("p6_latency", e_edge - s_edge, 6);
    chk("p6_result", out_flat, gold_v6);
    @(posedge clk); #1;

    // Back-to-back p6: start held high through the DONE cycle.
    mode  = 1'b1;
    set_in(VEC_P6);
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(d1);
    chk("b2b_first_result", out_flat, gold_v6);
    chk_int("b2b_busy_in_done", int'(busy), 0);
    set_in(VEC_B);
    @(posedge clk); #1;
    start = 1'b0;
    chk_int("b2b_busy_restart", int'(busy), 1);
    chk_int("b2b_round_restart", int'(rnd), 6);
    wait_done(d2);
    chk_int("b2b_done_spacing", d2 - d1, 7);
    chk("b2b_second_result", out_flat, gold_b6);

    // Idle hold for 20 cycles.
    repeat (20) begin
      @(posedge clk); #1;
      chk_int("idle_done_o", int'(done), 0);
      chk_int("idle_busy_o", int'(busy), 0);
    end
    chk("idle_state_o", out_flat, gold_b6);
    chk_int("idle_round_o", int'(rnd), 12);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
